// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit registers (offsets 0x0/0x4/0x8/0xC)
// to user logic, with independent write and read state machines.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response channels
//   S_AXI_AR* / S_AXI_R*            : read address and data channels
//   slv_regs_o     : {reg3, reg2, reg1, reg0}
//   reg_wr_pulse_o : one-cycle strobe for the register being committed
//
// Build option: define AXI_LITE_WSTRB_EN to honour WSTRB byte enables;
// otherwise every write replaces the whole 32-bit register.
//
// All outputs come from flops or from decoded flop state, so none has a
// combinational path from any input.

module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,

    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_regs_o,
    output logic [3:0]                        reg_wr_pulse_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] wr_val_d;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wstate_e       wstate_q, wstate_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic [1:0]    wr_idx_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;

    logic          aw_hs;
    logic          w_hs;
    logic          wr_commit;
    logic          bvalid;
    logic [3:0]    wr_pulse;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rstate_e       rstate_q, rstate_d;
    logic          arready_q, arready_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          ar_hs;
    logic          rvalid;

    // Handshakes only ever use registered READY flags.
    assign aw_hs = awready_q & S_AXI_AWVALID;
    assign w_hs  = wready_q  & S_AXI_WVALID;
    assign ar_hs = arready_q & S_AXI_ARVALID;

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wr_idx_q  <= 2'd0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            if (aw_hs) begin
                wr_idx_q <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state
    // AW and W are latched independently; COMMIT starts once both held.
    // ------------------------------------------------------------------
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        unique case (wstate_q)
            W_IDLE: begin
                aw_held_d = aw_held_q | aw_hs;
                w_held_d  = w_held_q | w_hs;
                if (aw_held_d && w_held_d) begin
                    wstate_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                wstate_d  = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d = W_IDLE;
                end
            end
            default: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                wstate_d  = W_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: outputs
    // READY flags are precomputed from the next state so they are
    // registered; each drops the cycle after its own channel is captured.
    // ------------------------------------------------------------------
    always_comb begin
        awready_d = (wstate_d == W_IDLE) && !aw_held_d;
        wready_d  = (wstate_d == W_IDLE) && !w_held_d;
        wr_commit = (wstate_q == W_COMMIT);
        bvalid    = (wstate_q == W_RESP);
        wr_pulse  = 4'b0000;
        if (wr_commit) begin
            wr_pulse = 4'b0001 << wr_idx_q;
        end
    end

    // ------------------------------------------------------------------
    // Commit data merge
    // ------------------------------------------------------------------
    always_comb begin
`ifdef AXI_LITE_WSTRB_EN
        wr_val_d = regs_q[wr_idx_q];
        for (int b = 0; b < SW; b++) begin
            if (wstrb_q[b]) begin
                wr_val_d[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
`else
        wr_val_d = wdata_q;
`endif
    end

    // Reset takes priority, so a write sitting in COMMIT is dropped.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_idx_q] <= wr_val_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: next state
    // The register file is sampled at the AR handshake edge, so a commit
    // on that same edge is not yet visible: the read returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        unique case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_d = R_IDLE;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        arready_d = (rstate_d == R_IDLE);
        rvalid    = (rstate_q == R_DATA);
    end

    // ------------------------------------------------------------------
    // Port assignments
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = wready_q;
    assign S_AXI_BVALID   = bvalid;
    assign S_AXI_BRESP    = 2'b00;
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RVALID   = rvalid;
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = 2'b00;
    assign reg_wr_pulse_o = wr_pulse;
    assign slv_regs_o     = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

    // Protection bits, byte-offset bits and (without byte enables) the
    // strobes carry no meaning for this register block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR, S_AXI_ARADDR, wstrb_q};

endmodule
